// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32 load/store sequencer.
// Word loads/stores go straight to memory. Sub-word stores do a read-modify-write
// of the containing word. Misaligned or illegal requests complete with a fault
// and never touch memory.
module load_store_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        iStart,
  input  logic        iLoad,
  input  logic        iStore,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  output logic        oBusy,
  output logic        oDone,
  output logic        oFault,
  output logic [31:0] oLoadData,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic [31:0] oMemAddress,
  output logic [31:0] oMemWData,
  input  logic [31:0] iMemRData
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [29:0] waddr_q, waddr_d;   // word address, becomes oMemAddress[31:2]
  logic [1:0]  off_q,   off_d;     // byte offset inside the word
  logic [2:0]  funct3_q, funct3_d;
  logic [15:0] sdata_q, sdata_d;   // sub-word store data; word stores bypass it
  logic        load_q,  load_d;
  logic        fault_q, fault_d;
  logic [31:0] ldata_q, ldata_d;
  logic [31:0] wword_q, wword_d;

  logic        req_half, req_word, bad_f3, req_fault;
  logic [31:0] rd_shift, ld_ext, st_mask, st_data, st_merge;
  logic [15:0] rd_half;

  // Classify the incoming request: wrong direction, illegal size or misalignment.
  always_comb begin
    req_half  = (iFunct3[1:0] == 2'b01);
    req_word  = (iFunct3 == 3'b010);
    bad_f3    = iLoad ? ((iFunct3 == 3'b011) || (iFunct3[2:1] == 2'b11))
                      : ((iFunct3 == 3'b011) || iFunct3[2]);
    req_fault = (iLoad == iStore) || bad_f3 ||
                (req_half && iAddress[0]) ||
                (req_word && (iAddress[1:0] != 2'b00));
  end

  // Load lane select/extend and store merge, both working on the returned word.
  always_comb begin
    rd_shift = iMemRData >> {off_q, 3'b000};
    rd_half  = off_q[1] ? iMemRData[31:16] : iMemRData[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  ld_ext = {24'h0, rd_shift[7:0]};
      3'b101:  ld_ext = {16'h0, rd_half};
      default: ld_ext = iMemRData;
    endcase
    if (funct3_q[1:0] == 2'b00) begin
      st_mask = 32'h0000_00FF << {off_q, 3'b000};
      st_data = {4{sdata_q[7:0]}};
    end else begin
      st_mask = off_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      st_data = {2{sdata_q}};
    end
    st_merge = (iMemRData & ~st_mask) | (st_data & st_mask);
  end

  // Next-state and datapath update; iStart only matters in IDLE.
  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    off_d    = off_q;
    funct3_d = funct3_q;
    sdata_d  = sdata_q;
    load_d   = load_q;
    fault_d  = fault_q;
    ldata_d  = ldata_q;
    wword_d  = wword_q;
    case (state_q)
      S_IDLE: if (iStart) begin
        waddr_d  = iAddress[31:2];
        off_d    = iAddress[1:0];
        funct3_d = iFunct3;
        sdata_d  = iWriteData[15:0];
        load_d   = iLoad;
        fault_d  = req_fault;
        if (req_fault) begin
          state_d = S_DONE;
        end else if (iStore && req_word) begin
          wword_d = iWriteData;
          state_d = S_WRITE;
        end else begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (load_q) begin
          ldata_d = ld_ext;
          state_d = S_DONE;
        end else begin
          wword_d = st_merge;
          state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE: begin
        fault_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any access immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      waddr_q  <= '0;
      off_q    <= '0;
      funct3_q <= '0;
      sdata_q  <= '0;
      load_q   <= 1'b0;
      fault_q  <= 1'b0;
      ldata_q  <= '0;
      wword_q  <= '0;
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      off_q    <= off_d;
      funct3_q <= funct3_d;
      sdata_q  <= sdata_d;
      load_q   <= load_d;
      fault_q  <= fault_d;
      ldata_q  <= ldata_d;
      wword_q  <= wword_d;
    end
  end

  assign oBusy       = (state_q != S_IDLE);
  assign oDone       = (state_q == S_DONE);
  assign oMemRead    = (state_q == S_READ);
  assign oMemWrite   = (state_q == S_WRITE);
  assign oFault      = fault_q;
  assign oLoadData   = ldata_q;
  assign oMemAddress = {waddr_q, 2'b00};
  assign oMemWData   = wword_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random requests against a word-array memory,
// checked against a request-level reference model.
module tb_load_store_unit;
  logic        clock = 1'b0;
  logic        reset, iStart, iLoad, iStore;
  logic [2:0]  iFunct3;
  logic [31:0] iAddress, iWriteData, iMemRData;
  logic        oBusy, oDone, oFault, oMemRead, oMemWrite;
  logic [31:0] oLoadData, oMemAddress, oMemWData;

  load_store_unit dut (
    .clock(clock), .reset(reset), .iStart(iStart), .iLoad(iLoad), .iStore(iStore),
    .iFunct3(iFunct3), .iAddress(iAddress), .iWriteData(iWriteData),
    .oBusy(oBusy), .oDone(oDone), .oFault(oFault), .oLoadData(oLoadData),
    .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oMemAddress(oMemAddress),
    .oMemWData(oMemWData), .iMemRData(iMemRData)
  );

  always #5 clock = ~clock;

  int errors = 0, checks = 0;
  int nrd = 0, nwr = 0, ndone = 0;
  bit both = 0, mem_init = 1;
  logic [31:0] last_waddr = '0;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] exp_ld;

  function automatic logic [31:0] init_word(int i);
    return 32'(i + 1) * 32'h9E37_79B9;
  endfunction

  // memory: write at rising edge, read data presented on falling edge
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (oMemWrite) begin
      mem[oMemAddress[5:2]] <= oMemWData;
      nwr <= nwr + 1;
      last_waddr <= oMemAddress;
    end
  end

  always @(negedge clock) begin
    iMemRData <= oMemRead ? mem[oMemAddress[5:2]] : $urandom;
    if (oMemRead) nrd <= nrd + 1;
    if (oDone) ndone <= ndone + 1;
    if (oMemRead && oMemWrite) both <= 1'b1;
  end

  // ---------------- reference model ----------------
  function automatic bit ref_fault(bit ld, bit st, logic [2:0] f3, logic [31:0] a);
    if (ld == st) return 1;
    if (ld && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1;
    if (st && f3 > 2) return 1;
    if ((f3 == 1 || f3 == 5) && a[0]) return 1;
    if (f3 == 2 && a[1:0] != 0) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] w, logic [2:0] f3, logic [31:0] a);
    int off = int'(a[1:0]);
    logic [31:0] b = (w >> (8 * off)) & 32'hFF;
    logic [31:0] h = (w >> (8 * (off & 2))) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 128) ? b - 256 : b;
      3'd1: return (h >= 32768) ? h - 65536 : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(logic [31:0] old, logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    logic [31:0] r = old;
    int off = int'(a[1:0]);
    if (f3 == 2) r = d;
    else if (f3 == 0) r[8*off +: 8] = d[7:0];
    else r[8*(off & 2) +: 16] = d[15:0];
    return r;
  endfunction

  // one request end to end; synced=1 means inputs may be driven right now
  task automatic do_req(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit spam, input bit synced, input string nm);
    bit flt = ref_fault(ld, st, f3, a);
    int lat_exp = flt ? 1 : ((st && f3 != 2) ? 3 : 2);
    int rd_exp = (!flt && (ld || f3 != 2)) ? 1 : 0;
    int wr_exp = (!flt && st) ? 1 : 0;
    int rd0, wr0, dn0, lat = 0;
    bit got = 0, bad;
    if (!flt) begin
      if (ld) exp_ld = ref_load(ref_mem[a[5:2]], f3, a);
      else ref_mem[a[5:2]] = ref_store(ref_mem[a[5:2]], f3, a, d);
    end
    if (!synced) begin @(posedge clock); #1; end
    rd0 = nrd; wr0 = nwr; dn0 = ndone;
    iStart = 1; iLoad = ld; iStore = st; iFunct3 = f3; iAddress = a; iWriteData = d;
    @(posedge clock); #1;
    if (!spam) iStart = 0;
    while (lat < 8 && !got) begin
      @(negedge clock); lat++;
      if (lat == 1) begin
        checks++;
        if (oBusy !== 1'b1) begin errors++; $display("FAIL %s busy: got %b want 1", nm, oBusy); end
      end
      if (oDone === 1'b1) got = 1;
      else if (spam) begin
        iLoad = $urandom; iStore = $urandom; iFunct3 = $urandom;
        iAddress = $urandom; iWriteData = $urandom;
      end
    end
    iStart = 0;
    checks++;
    if (!got || lat != lat_exp) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, got ? lat : -1, lat_exp); end
    checks++;
    if (oFault !== flt) begin errors++; $display("FAIL %s fault: got %b want %b", nm, oFault, flt); end
    checks++;
    if (oLoadData !== exp_ld) begin errors++; $display("FAIL %s loaddata: got %h want %h", nm, oLoadData, exp_ld); end
    @(posedge clock); #1;
    checks++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oFault !== 1'b0) begin
      errors++; $display("FAIL %s idle: busy=%b done=%b fault=%b want 0", nm, oBusy, oDone, oFault);
    end
    checks++;
    if (nrd - rd0 != rd_exp || nwr - wr0 != wr_exp || ndone - dn0 != 1) begin
      errors++; $display("FAIL %s strobes: rd=%0d wr=%0d done=%0d want %0d %0d 1", nm, nrd-rd0, nwr-wr0, ndone-dn0, rd_exp, wr_exp);
    end
    if (wr_exp == 1) begin
      checks++;
      if (last_waddr !== {a[31:2], 2'b00}) begin errors++; $display("FAIL %s waddr: got %h want %h", nm, last_waddr, {a[31:2], 2'b00}); end
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL %s memory: word %h want %h", nm, mem[a[5:2]], ref_mem[a[5:2]]); end
  endtask

  task automatic test_reset();
    reset = 1; iStart = 0; iLoad = 0; iStore = 0; iFunct3 = 0; iAddress = 0; iWriteData = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    exp_ld = 0;
    @(posedge clock); #1; mem_init = 0;
    @(posedge clock); #1;
    checks++;
    if ({oBusy, oDone, oFault, oMemRead, oMemWrite} !== 5'b0 || oLoadData !== 0 ||
        oMemAddress !== 0 || oMemWData !== 0) begin
      errors++; $display("FAIL reset_state: busy=%b done=%b fault=%b ld=%h addr=%h wd=%h want 0",
                         oBusy, oDone, oFault, oLoadData, oMemAddress, oMemWData);
    end
    reset = 0;  // request driven in the same cycle reset drops
    do_req(0, 1, 3'd2, 32'h1001_0004, 32'hDEAD_BEEF, 0, 1, "sw_after_reset");
  endtask

  task automatic test_word_and_subword_loads();
    do_req(1, 0, 3'd2, 32'h1001_0004, 32'h0, 0, 0, "lw");
    do_req(1, 0, 3'd0, 32'h1001_0007, 32'h0, 0, 0, "lb");
    do_req(1, 0, 3'd4, 32'h1001_0007, 32'h0, 0, 0, "lbu");
    do_req(1, 0, 3'd1, 32'h1001_0004, 32'h0, 0, 0, "lh");
    do_req(1, 0, 3'd5, 32'h1001_0004, 32'h0, 0, 0, "lhu");
  endtask

  task automatic test_subword_stores();
    do_req(0, 1, 3'd0, 32'h1001_0005, 32'h0000_0055, 0, 0, "sb");
    do_req(1, 0, 3'd2, 32'h1001_0004, 32'h0, 0, 0, "lw_after_sb");
    do_req(0, 1, 3'd2, 32'h1001_0004, 32'hDEAD_BEEF, 0, 0, "sw_restore");
    do_req(0, 1, 3'd1, 32'h1001_0006, 32'h0000_1234, 0, 0, "sh");
    do_req(1, 0, 3'd2, 32'h1001_0004, 32'h0, 0, 0, "lw_after_sh");
  endtask

  task automatic test_faults();
    do_req(1, 0, 3'd1, 32'h1001_0003, 32'h0, 0, 0, "flt_lh_mis");
    do_req(1, 0, 3'd2, 32'h1001_0002, 32'h0, 0, 0, "flt_lw_mis");
    do_req(1, 1, 3'd2, 32'h1001_0004, 32'h0, 0, 0, "flt_both");
    do_req(0, 0, 3'd2, 32'h1001_0004, 32'h0, 0, 0, "flt_none");
    do_req(1, 0, 3'd3, 32'h1001_0004, 32'h0, 0, 0, "flt_f3_011");
    do_req(0, 1, 3'd4, 32'h1001_0004, 32'h1, 0, 0, "flt_sbu");
    do_req(0, 1, 3'd1, 32'h1001_0005, 32'h1, 0, 0, "flt_sh_mis");
  endtask

  task automatic test_reset_mid_op();
    bit bad = 0;
    int wr0;
    @(posedge clock); #1;
    wr0 = nwr;
    iStart = 1; iLoad = 0; iStore = 1; iFunct3 = 3'd1; iAddress = 32'h1001_0006; iWriteData = 32'h0000_ABCD;
    @(posedge clock); #1; iStart = 0;
    checks++;
    if (oMemRead !== 1'b1) begin errors++; $display("FAIL mid_reset_read: got %b want 1", oMemRead); end
    #2 reset = 1; #1;
    checks++;
    if ({oBusy, oMemRead, oMemWrite, oDone} !== 4'b0 || oLoadData !== 0) begin
      errors++; $display("FAIL mid_reset_drop: busy=%b rd=%b wr=%b done=%b ld=%h want 0",
                         oBusy, oMemRead, oMemWrite, oDone, oLoadData);
    end
    exp_ld = 0;
    @(posedge clock); @(posedge clock); @(negedge clock); reset = 0;
    @(posedge clock); #1;
    for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) bad = 1;
    checks++;
    if (bad || nwr != wr0) begin errors++; $display("FAIL mid_reset_mem: writes=%0d word=%h want 0 %h", nwr-wr0, mem[1], ref_mem[1]); end
    do_req(1, 0, 3'd2, 32'h1001_0004, 32'h0, 0, 1, "lw_after_abort");
  endtask

  task automatic test_back_to_back();
    do_req(0, 1, 3'd0, 32'h1001_000A, 32'h0000_00C3, 1, 0, "sb_spam");
    do_req(1, 0, 3'd2, 32'h1001_0004, 32'h0, 1, 0, "lw_spam");
    do_req(1, 0, 3'd2, 32'h1001_0008, 32'h0, 0, 0, "lw_after_spam");
  endtask

  task automatic test_random();
    logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int n = 0; n < 80; n++) begin
      bit ld = $urandom_range(0, 1);
      bit st = ($urandom_range(0, 7) == 0) ? ld : !ld;
      logic [2:0] f3;
      logic [31:0] a;
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
      else if (ld) f3 = lf[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 2));
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'h1001_0000 + $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 0 && f3[1:0] != 0) a[1:0] = f3[1] ? 2'b00 : {a[1], 1'b0};
      do_req(ld, st, f3, a, $urandom, $urandom_range(0, 3) == 0, 0, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_word_and_subword_loads();
    test_subword_stores();
    test_faults();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    checks++;
    if (both !== 1'b0) begin errors++; $display("FAIL strobe_excl: read and write high together (%b) want 0", both); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have no parameters; widths fixed: address/data 32, funct3 3.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 iStart  input  1  request strobe; sampled only in IDLE.
REQ-005 iLoad  input  1  request is a load.
REQ-006 iStore  input  1  request is a store.
REQ-007 iFunct3  input  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-008 iAddress  input  32  byte address of access.
REQ-009 iWriteData  input  32  store data, right-aligned.
REQ-010 oBusy  output  1  high in every non-IDLE state.
REQ-011 oDone  output  1  one-cycle completion pulse.
REQ-012 oFault  output  1  valid with oDone; request rejected, no memory access made.
REQ-013 oLoadData  output  32  extended load result; held until next accepted load.
REQ-014 oMemRead  output  1  word read strobe to data memory.
REQ-015 oMemWrite  output  1  word write strobe to data memory.
REQ-016 oMemAddress  output  32  {addr[31:2],2'b00}, registered at accept.
REQ-017 oMemWData  output  32  full word written to memory.
REQ-018 iMemRData  input  32  memory read word; valid at the rising edge ending a READ cycle (memory drives it on the falling edge).

Function
REQ-019 FSM states SHALL be IDLE, READ, WRITE, DONE; strobes decoded from state only (READ->oMemRead, WRITE->oMemWrite, DONE->oDone).
REQ-020 In IDLE with iStart=1 the unit SHALL latch address, funct3, data and type, then move: word load or any sub-word op -> READ; word store -> WRITE; fault -> DONE.
REQ-021 Fault SHALL be: iLoad==iStore; illegal funct3 (load 011/110/111, store other than 000/001/010); halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-022 READ SHALL last exactly one cycle; at its closing edge iMemRData is captured; load -> DONE, store -> WRITE.
REQ-023 Loads SHALL select byte addr[1:0] / halfword addr[1], sign-extend for B/H, zero-extend for BU/HU, pass W unchanged; oLoadData updates at the READ closing edge.
REQ-024 Sub-word stores SHALL merge: replace only the addressed byte (data[7:0]) or halfword (data[15:0]) in the captured word; other bytes unchanged.
REQ-025 WRITE SHALL last exactly one cycle with oMemWData stable; next state DONE.
REQ-026 DONE SHALL last one cycle, then IDLE; oFault cleared on leaving DONE.
REQ-027 oMemRead and oMemWrite SHALL never be high together.
REQ-028 iStart outside IDLE SHALL be ignored; no queuing.
REQ-029 Latency from accept edge N: fault oDone in cycle N+1; word load/store N+2; sub-word store N+3.
REQ-030 Address arithmetic SHALL be unsigned 32-bit, no range check; wrap is the memory's concern.

Reset
REQ-031 reset SHALL force IDLE and zero oBusy, oDone, oFault, oLoadData, oMemRead, oMemWrite, oMemAddress, oMemWData and all internal registers, asynchronously.
REQ-032 Reset mid-operation SHALL abort with no further strobe; a sub-word store aborted in READ SHALL leave memory unchanged.
REQ-033 First request after reset release SHALL be accepted on the first rising edge with reset low.

Verification
REQ-034 SW addr 0x10010004 data 0xDEADBEEF -> oMemWrite 1 cycle, oMemAddress 0x10010004, oMemWData 0xDEADBEEF, oDone at N+2; following LW returns 0xDEADBEEF.
REQ-035 Word 0xDEADBEEF at 0x10010004: LB 0x10010007 -> 0xFFFFFFDE; LBU -> 0x000000DE; LH 0x10010004 -> 0xFFFFBEEF; LHU -> 0x0000BEEF.
REQ-036 SB 0x10010005 data 0x00000055 over 0xDEADBEEF -> READ then WRITE of 0xDEAD55EF, oDone at N+3; SH 0x10010006 data 0x1234 -> 0x1234BEEF.
REQ-037 LH 0x10010003, LW 0x10010002, iLoad=iStore=1, load funct3 011 -> oDone+oFault at N+1, no strobe, oLoadData unchanged.
REQ-038 Reset asserted during READ of SH -> strobes and oBusy drop immediately, memory word unchanged, next LW accepted normally.
REQ-039 iStart pulsed every cycle during a sub-word store -> only the first request executes; exactly one oDone per accepted request.
